// File: rtl/mem_stage.sv
// Memory (ME) stage of the 5-stage MIPS pipeline.
// Issues word loads/stores over a req/ack handshake with variable latency,
// stalls the pipe while an access is outstanding and registers the ME->WB
// result, which doubles as the ME bypass source for EX.
module mem_stage #(
  parameter int DM_TIMEOUT = 255,
  parameter int TO_W       = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        AnyStall,
  input  logic [31:0] Result_EX,
  input  logic [31:0] WrDat_EX,
  input  logic [4:0]  WriteReg_EX,
  input  logic        RegWrite_EX,
  input  logic        MemToReg_EX,
  input  logic        MemWrite_EX,
  output logic        DmReq,
  output logic        DmWe,
  output logic [31:0] DmAddr,
  output logic [31:0] DmWrDat,
  input  logic        DmAck,
  input  logic [31:0] DmRdDat,
  output logic [31:0] ResultRdDat_ME,
  output logic [4:0]  WriteReg_ME,
  output logic        RegWrite_ME,
  output logic        Stall_ME,
  output logic        AlignErr_ME,
  output logic        DmTimeout
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0]     buf_q, buf_d;
  logic            req_we_q, req_we_d;
  logic [31:0]     req_addr_q, req_addr_d;
  logic [31:0]     req_dat_q, req_dat_d;
  logic [31:0]     res_q, res_d;
  logic [4:0]      wreg_q, wreg_d;
  logic            rw_q, rw_d;
  logic            al_q, al_d;
  logic            tmo_q, tmo_d;

  logic        mem_op, aligned, issue, abort, upd, bubble;
  logic [31:0] ld_dat;

  // FSM next state: the request is captured at issue so it stays stable in
  // WAIT/DRAIN even if EX is flushed underneath it.
  always_comb begin
    mem_op     = MemToReg_EX | MemWrite_EX;
    aligned    = (Result_EX[1:0] == 2'b00);
    issue      = (state_q == S_IDLE) & mem_op & aligned;
    abort      = (state_q == S_WAIT) & ~DmAck & (cnt_q == TO_W'(DM_TIMEOUT));
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    req_we_d   = req_we_q;
    req_addr_d = req_addr_q;
    req_dat_d  = req_dat_q;
    tmo_d      = tmo_q;
    upd        = 1'b0;
    bubble     = 1'b0;
    al_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (issue) begin
          req_we_d   = MemWrite_EX;
          req_addr_d = {Result_EX[31:2], 2'b00};
          req_dat_d  = WrDat_EX;
          cnt_d      = TO_W'(1);
          if (DmAck) begin
            // zero-wait ack under an external stall is buffered so the
            // access is never re-issued
            if (AnyStall && !flush) begin
              buf_d   = DmRdDat;
              state_d = S_DONE;
            end else begin
              upd = ~AnyStall;
            end
          end else begin
            state_d = flush ? S_DRAIN : S_WAIT;
          end
        end else begin
          // non-memory op, or a misaligned access that is dropped
          upd    = ~AnyStall;
          bubble = mem_op;
          al_d   = mem_op & ~AnyStall;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + TO_W'(1);
        if (DmAck) begin
          buf_d = DmRdDat;
          if (AnyStall && !flush) begin
            state_d = S_DONE;
          end else begin
            upd     = ~AnyStall;
            state_d = S_IDLE;
          end
        end else if (abort) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (!AnyStall) begin
          upd     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (DmAck) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ME->WB datapath: loads take memory (or buffered) data, others the ALU result
  always_comb begin
    ld_dat = (state_q == S_DONE) ? buf_q : DmRdDat;
    res_d  = res_q;
    wreg_d = wreg_q;
    rw_d   = rw_q;
    if (upd) begin
      res_d  = MemToReg_EX ? ld_dat : Result_EX;
      wreg_d = WriteReg_EX;
      rw_d   = RegWrite_EX & ~bubble;
    end
    if (abort || flush) rw_d = 1'b0;
  end

  // Memory interface and stall; everything is held low while in reset
  always_comb begin
    DmReq    = 1'b0;
    DmWe     = 1'b0;
    DmAddr   = 32'h0;
    DmWrDat  = 32'h0;
    Stall_ME = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        S_IDLE: begin
          DmReq    = issue;
          DmWe     = MemWrite_EX;
          DmAddr   = {Result_EX[31:2], 2'b00};
          DmWrDat  = WrDat_EX;
          Stall_ME = issue & ~DmAck;
        end
        S_WAIT: begin
          DmReq    = ~abort;
          DmWe     = req_we_q;
          DmAddr   = req_addr_q;
          DmWrDat  = req_dat_q;
          Stall_ME = ~DmAck & ~abort;
        end
        S_DONE: begin
          DmWe    = req_we_q;
          DmAddr  = req_addr_q;
          DmWrDat = req_dat_q;
        end
        S_DRAIN: begin
          DmReq    = 1'b1;
          DmWe     = req_we_q;
          DmAddr   = req_addr_q;
          DmWrDat  = req_dat_q;
          Stall_ME = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      buf_q      <= 32'h0;
      req_we_q   <= 1'b0;
      req_addr_q <= 32'h0;
      req_dat_q  <= 32'h0;
      res_q      <= 32'h0;
      wreg_q     <= 5'h0;
      rw_q       <= 1'b0;
      al_q       <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      req_we_q   <= req_we_d;
      req_addr_q <= req_addr_d;
      req_dat_q  <= req_dat_d;
      res_q      <= res_d;
      wreg_q     <= wreg_d;
      rw_q       <= rw_d;
      al_q       <= al_d;
      tmo_q      <= tmo_d;
    end
  end

  assign ResultRdDat_ME = res_q;
  assign WriteReg_ME    = wreg_q;
  assign RegWrite_ME    = rw_q;
  assign AlignErr_ME    = al_q;
  assign DmTimeout      = tmo_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: the bench plays EX stage, external
// stall source and data memory, and predicts per-instruction outcomes.
module tb_mem_stage;
  localparam int TMO  = 6;
  localparam int K_AL = 0;
  localparam int K_LD = 1;
  localparam int K_ST = 2;

  logic        clk = 1'b0, reset_n = 1'b0, flush = 1'b0, ext_stall = 1'b0;
  logic        AnyStall;
  logic [31:0] Result_EX = '0, WrDat_EX = '0;
  logic [4:0]  WriteReg_EX = '0;
  logic        RegWrite_EX = 1'b0, MemToReg_EX = 1'b0, MemWrite_EX = 1'b0;
  logic        DmReq, DmWe;
  logic [31:0] DmAddr, DmWrDat;
  logic        DmAck = 1'b0;
  logic [31:0] DmRdDat = '0;
  logic [31:0] ResultRdDat_ME;
  logic [4:0]  WriteReg_ME;
  logic        RegWrite_ME, Stall_ME, AlignErr_ME, DmTimeout;

  int errs = 0, checks = 0;
  bit tmo_seen = 1'b0;

  assign AnyStall = ext_stall | Stall_ME;
  always #5 clk = ~clk;

  mem_stage #(.DM_TIMEOUT(TMO), .TO_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .AnyStall(AnyStall),
    .Result_EX(Result_EX), .WrDat_EX(WrDat_EX), .WriteReg_EX(WriteReg_EX),
    .RegWrite_EX(RegWrite_EX), .MemToReg_EX(MemToReg_EX), .MemWrite_EX(MemWrite_EX),
    .DmReq(DmReq), .DmWe(DmWe), .DmAddr(DmAddr), .DmWrDat(DmWrDat),
    .DmAck(DmAck), .DmRdDat(DmRdDat),
    .ResultRdDat_ME(ResultRdDat_ME), .WriteReg_ME(WriteReg_ME), .RegWrite_ME(RegWrite_ME),
    .Stall_ME(Stall_ME), .AlignErr_ME(AlignErr_ME), .DmTimeout(DmTimeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One instruction through ME. lat = cycles from request to ack (-1: never),
  // es = external stall cycles starting at the completion cycle,
  // fl = cycle (>0) in which flush is pulsed, junk = stray ack with no request.
  task automatic run_op(input int kind, input logic [31:0] res, input logic [31:0] wd,
                        input logic [4:0] rd, input logic rw, input int lat, input int es,
                        input int fl, input logic [31:0] rdat, input bit junk);
    bit mis, acc, tmo, fld, done, stl, fl_now;
    int ack_cyc, cyc, nreq, nstall, nal, nbad, exp_ret, exp_stall, exp_req;
    logic [31:0] waddr, exp_res;
    logic exp_rw;
    mis     = (kind != K_AL) && (res[1:0] != 2'b00);
    acc     = (kind != K_AL) && !mis;
    tmo     = acc && (lat < 0);
    fld     = acc && (fl > 0);
    ack_cyc = acc ? lat : 0;
    waddr   = {res[31:2], 2'b00};
    cyc = 0; nreq = 0; nstall = 0; nal = 0; nbad = 0; done = 1'b0;
    Result_EX = res; WrDat_EX = wd; WriteReg_EX = rd; RegWrite_EX = rw;
    MemToReg_EX = (kind == K_LD); MemWrite_EX = (kind == K_ST);
    while (!done && cyc < 60) begin
      fl_now    = fld && (cyc == fl);
      flush     = fl_now;
      ext_stall = !tmo && !fld && (cyc >= ack_cyc) && (cyc < ack_cyc + es);
      DmAck     = acc ? (!tmo && cyc == lat) : (junk && cyc == 0);
      DmRdDat   = (acc && cyc == lat) ? rdat : $urandom;
      #1;
      if (DmReq) begin
        nreq++;
        if (DmAddr !== waddr || DmWe !== (kind == K_ST) || DmWrDat !== wd) nbad++;
      end
      if (Stall_ME) nstall++;
      stl = AnyStall;
      @(posedge clk); #1;
      if (AlignErr_ME) nal++;
      if (fl_now) begin
        Result_EX = '0; WrDat_EX = '0; WriteReg_EX = '0;
        RegWrite_EX = 1'b0; MemToReg_EX = 1'b0; MemWrite_EX = 1'b0;
      end
      if (!stl) done = 1'b1;
      else cyc++;
      @(negedge clk);
    end
    flush = 1'b0; ext_stall = 1'b0; DmAck = 1'b0;

    exp_ret   = tmo ? TMO : fld ? lat + 1 : ack_cyc + es;
    exp_stall = tmo ? TMO : fld ? lat + 1 : (acc ? lat : 0);
    exp_req   = !acc ? 0 : tmo ? TMO : lat + 1;
    exp_rw    = (mis || tmo || fld || kind == K_ST) ? 1'b0 : rw;
    exp_res   = (kind == K_LD) ? rdat : res;
    chk("completed", done, 1);
    chk("retire_cycle", cyc, exp_ret);
    chk("stall_cycles", nstall, exp_stall);
    chk("req_cycles", nreq, exp_req);
    chk("req_stable", nbad, 0);
    chk("regwrite", RegWrite_ME, exp_rw);
    if (fld) begin
      chk("flush_result", ResultRdDat_ME, 0);
      chk("flush_wreg", WriteReg_ME, 0);
    end else if (!mis && !tmo) begin
      chk("result", ResultRdDat_ME, exp_res);
      chk("wreg", WriteReg_ME, rd);
    end
    chk("alignerr_pulses", nal, mis);
    if (tmo) tmo_seen = 1'b1;
    chk("timeout_flag", DmTimeout, tmo_seen);
  endtask

  initial begin
    int k, lat, es, fl;
    logic [31:0] a;
    logic rw;
    #1;
    chk("rst_dmreq", DmReq, 0);
    chk("rst_stall", Stall_ME, 0);
    chk("rst_result", ResultRdDat_ME, 0);
    chk("rst_wreg", WriteReg_ME, 0);
    chk("rst_regwrite", RegWrite_ME, 0);
    chk("rst_alignerr", AlignErr_ME, 0);
    chk("rst_timeout", DmTimeout, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(K_AL, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 0, 0, 32'h0, 1'b0);
    run_op(K_LD, 32'h100, 32'h0, 5'd7, 1'b1, 0, 0, 0, 32'hCAFEF00D, 1'b0);
    run_op(K_ST, 32'h204, 32'hA5A5A5A5, 5'd0, 1'b0, 3, 0, 0, 32'h0, 1'b0);
    run_op(K_LD, 32'h400, 32'h0, 5'd9, 1'b1, 2, 3, 0, 32'h12345678, 1'b0);
    run_op(K_LD, 32'h700, 32'h0, 5'd10, 1'b1, 0, 2, 0, 32'h0BADCAFE, 1'b0);
    run_op(K_LD, 32'h102, 32'h0, 5'd4, 1'b1, 0, 0, 0, 32'h0, 1'b0);
    run_op(K_LD, 32'h500, 32'h0, 5'd6, 1'b1, -1, 0, 0, 32'h0, 1'b0);
    run_op(K_LD, 32'h600, 32'h0, 5'd8, 1'b1, 3, 0, 1, 32'hBEEF, 1'b0);
    run_op(K_AL, 32'h77, 32'h0, 5'd3, 1'b1, 0, 0, 0, 32'h0, 1'b1);

    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 2);
      a = $urandom;
      if (k != K_AL && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      lat = $urandom_range(0, TMO - 1);
      if ($urandom_range(0, 15) == 0) lat = -1;
      es = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      fl = 0;
      if (k != K_AL && a[1:0] == 2'b00 && lat >= 2 && $urandom_range(0, 5) == 0)
        fl = $urandom_range(1, lat - 1);
      rw = (k == K_LD) ? 1'b1 : (k == K_ST) ? 1'b0 : 1'($urandom_range(0, 1));
      run_op(k, a, $urandom, 5'($urandom), rw, lat, es, fl, $urandom, 1'($urandom_range(0, 1)));
    end

    // reset in the middle of an outstanding load, then a stray late ack
    Result_EX = 32'h300; WriteReg_EX = 5'd3; RegWrite_EX = 1'b1; MemToReg_EX = 1'b1;
    #1;
    chk("pre_rst_req", DmReq, 1);
    repeat (2) @(negedge clk);
    chk("pre_rst_stall", Stall_ME, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_dmreq", DmReq, 0);
    chk("midrst_stall", Stall_ME, 0);
    @(negedge clk);
    Result_EX = '0; WriteReg_EX = '0; RegWrite_EX = 1'b0; MemToReg_EX = 1'b0;
    reset_n = 1'b1;
    DmAck = 1'b1; DmRdDat = 32'hDEADBEEF;
    #1;
    chk("late_ack_req", DmReq, 0);
    chk("late_ack_stall", Stall_ME, 0);
    @(posedge clk); #1;
    DmAck = 1'b0;
    tmo_seen = 1'b0;
    chk("late_ack_rw", RegWrite_ME, 0);
    chk("late_ack_result", ResultRdDat_ME, 0);
    chk("rst_clears_timeout", DmTimeout, tmo_seen);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errs);
    $fatal(1);
  end
endmodule
